// File: rtl/noc_pkg.sv
// Shared mesh-router definitions: port count, port indices, one-hot port
// vectors and the small index helpers used by the switch allocator.
package noc_pkg;

    localparam int NPORTS  = 5;

    localparam int P_LOCAL = 0;
    localparam int P_NORTH = 1;
    localparam int P_EAST  = 2;
    localparam int P_SOUTH = 3;
    localparam int P_WEST  = 4;

    typedef logic [NPORTS-1:0] port_vec_t;

    typedef struct packed {
        logic       vld;
        logic [2:0] idx;
    } port_idx_t;

    // vld is set only when exactly one bit is set; idx is then that bit's position.
    function automatic port_idx_t onehot_to_idx(input port_vec_t v);
        port_idx_t r;
        int        cnt;
        r   = '0;
        cnt = 0;
        for (int i = 0; i < NPORTS; i++) begin
            if (v[i]) begin
                cnt++;
                r.idx = 3'(i);
            end
        end
        r.vld = (cnt == 1);
        return r;
    endfunction

    function automatic logic [2:0] port_add(input logic [2:0] a, input int b);
        return 3'((int'(a) + b) % NPORTS);
    endfunction

endpackage

// File: rtl/rr_arbiter5.sv
// Round-robin arbiter for one crossbar output with wormhole locking.
// Purely combinational: the caller owns the lock/pointer registers.
module rr_arbiter5
    import noc_pkg::*;
(
    input  port_vec_t  req,
    input  port_vec_t  tail,
    input  logic       ready,
    input  logic [2:0] ptr,
    input  logic       lock_vld,
    input  logic [2:0] lock_owner,
    output port_vec_t  gnt,
    output logic [2:0] ptr_nxt,
    output logic       lock_vld_nxt,
    output logic [2:0] lock_owner_nxt
);

    logic       win_vld;
    logic [2:0] win;
    logic [2:0] cand;

    always_comb begin
        win_vld        = 1'b0;
        win            = '0;
        cand           = '0;
        gnt            = '0;
        ptr_nxt        = ptr;
        lock_vld_nxt   = lock_vld;
        lock_owner_nxt = lock_owner;

        if (lock_vld) begin
            // A locked output only ever serves its owner, bubbles included.
            if (ready && req[lock_owner]) begin
                win_vld = 1'b1;
                win     = lock_owner;
            end
        end else if (ready) begin
            // Scan from the far end so the candidate nearest ptr wins last.
            for (int k = NPORTS - 1; k >= 0; k--) begin
                cand = port_add(ptr, k);
                if (req[cand]) begin
                    win_vld = 1'b1;
                    win     = cand;
                end
            end
        end

        if (win_vld) begin
            gnt[win] = 1'b1;
            if (tail[win]) begin
                lock_vld_nxt = 1'b0;
                ptr_nxt      = port_add(win, 1);
            end else begin
                lock_vld_nxt   = 1'b1;
                lock_owner_nxt = win;
            end
        end
    end

endmodule

// File: rtl/switch_allocator.sv
// Five-port switch allocator: decodes route requests, runs one wormhole
// round-robin arbiter per output and drives crossbar selects and pops.
module switch_allocator
    import noc_pkg::*;
#(
    parameter int NPORTS  = 5,
    parameter int RR_INIT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NPORTS-1:0] req_valid,
    input  logic [NPORTS-1:0] req_dest0,
    input  logic [NPORTS-1:0] req_dest1,
    input  logic [NPORTS-1:0] req_dest2,
    input  logic [NPORTS-1:0] req_dest3,
    input  logic [NPORTS-1:0] req_dest4,
    input  logic [NPORTS-1:0] req_tail,
    input  logic [NPORTS-1:0] out_ready,
    output logic [NPORTS-1:0] grant,
    output logic [NPORTS-1:0] sel0,
    output logic [NPORTS-1:0] sel1,
    output logic [NPORTS-1:0] sel2,
    output logic [NPORTS-1:0] sel3,
    output logic [NPORTS-1:0] sel4,
    output logic [NPORTS-1:0] busy,
    output logic              err_dest
);

    port_vec_t                         dest [NPORTS];
    logic [NPORTS-1:0]                 bad_dest;
    logic [NPORTS-1:0][NPORTS-1:0]     req_out;
    logic [NPORTS-1:0][NPORTS-1:0]     gnt_out;
    logic [NPORTS-1:0]                 gnt_or;

    logic [NPORTS-1:0]                 lock_vld;
    logic [NPORTS-1:0][2:0]            lock_own;
    logic [NPORTS-1:0][2:0]            ptr;
    logic [NPORTS-1:0]                 lock_vld_nxt;
    logic [NPORTS-1:0][2:0]            lock_own_nxt;
    logic [NPORTS-1:0][2:0]            ptr_nxt;

    assign dest[0] = req_dest0;
    assign dest[1] = req_dest1;
    assign dest[2] = req_dest2;
    assign dest[3] = req_dest3;
    assign dest[4] = req_dest4;

    // Transpose per-input destinations into per-output request vectors.
    always_comb begin
        port_idx_t d;
        d        = '0;
        bad_dest = '0;
        req_out  = '0;
        for (int i = 0; i < NPORTS; i++) begin
            d = onehot_to_idx(dest[i]);
            if (req_valid[i]) begin
                if (d.vld) req_out[d.idx][i] = 1'b1;
                else       bad_dest[i]       = 1'b1;
            end
        end
    end

    for (genvar o = 0; o < NPORTS; o++) begin : g_out
        rr_arbiter5 u_arb (
            .req            (req_out[o]),
            .tail           (req_tail),
            .ready          (out_ready[o]),
            .ptr            (ptr[o]),
            .lock_vld       (lock_vld[o]),
            .lock_owner     (lock_own[o]),
            .gnt            (gnt_out[o]),
            .ptr_nxt        (ptr_nxt[o]),
            .lock_vld_nxt   (lock_vld_nxt[o]),
            .lock_owner_nxt (lock_own_nxt[o])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lock_vld <= '0;
            lock_own <= '0;
            for (int o = 0; o < NPORTS; o++) ptr[o] <= 3'(RR_INIT);
            err_dest <= 1'b0;
        end else begin
            lock_vld <= lock_vld_nxt;
            lock_own <= lock_own_nxt;
            ptr      <= ptr_nxt;
            if (|bad_dest) err_dest <= 1'b1;
        end
    end

    // Each input targets one output at most, so OR-ing never collides.
    always_comb begin
        gnt_or = '0;
        for (int o = 0; o < NPORTS; o++) gnt_or |= gnt_out[o];
    end

    assign grant = rst ? gnt_or     : '0;
    assign sel0  = rst ? gnt_out[0] : '0;
    assign sel1  = rst ? gnt_out[1] : '0;
    assign sel2  = rst ? gnt_out[2] : '0;
    assign sel3  = rst ? gnt_out[3] : '0;
    assign sel4  = rst ? gnt_out[4] : '0;
    assign busy  = rst ? lock_vld   : '0;

endmodule

// File: tb/tb_switch_allocator.sv
// Bench for switch_allocator: reference model checked every cycle plus
// directed scenarios with literal expectations.
module tb_switch_allocator;

    logic       clk;
    logic       rst;
    logic [4:0] rv;
    logic [4:0] rtail;
    logic [4:0] rdy;
    logic [4:0] dst [5];
    logic [4:0] grant;
    logic [4:0] sel [5];
    logic [4:0] busy;
    logic       err_dest;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    bit m_lock  [5];
    int m_owner [5];
    int m_ptr   [5];
    bit m_err;

    switch_allocator #(.NPORTS(5), .RR_INIT(0)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (rv),
        .req_dest0 (dst[0]),
        .req_dest1 (dst[1]),
        .req_dest2 (dst[2]),
        .req_dest3 (dst[3]),
        .req_dest4 (dst[4]),
        .req_tail  (rtail),
        .out_ready (rdy),
        .grant     (grant),
        .sel0      (sel[0]),
        .sel1      (sel[1]),
        .sel2      (sel[2]),
        .sel3      (sel[3]),
        .sel4      (sel[4]),
        .busy      (busy),
        .err_dest  (err_dest)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit wants(input int i, input int o);
        return rv[i] && ($countones(dst[i]) == 1) && dst[i][o];
    endfunction

    // Outputs implied by the allocation rules and the model's lock/pointer state.
    task automatic model_eval(output logic [4:0] g, output logic [4:0][4:0] s);
        g = '0;
        s = '0;
        if (rst) begin
            for (int o = 0; o < 5; o++) begin
                int w;
                w = -1;
                for (int off = 0; off < 5; off++) begin
                    int i;
                    i = (m_ptr[o] + off) % 5;
                    if (w < 0 && wants(i, o) && (!m_lock[o] || m_owner[o] == i)) w = i;
                end
                if (w >= 0 && rdy[o]) begin
                    s[o][w] = 1'b1;
                    g[w]    = 1'b1;
                end
            end
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int o = 0; o < 5; o++) begin
                m_lock[o]  = 0;
                m_owner[o] = 0;
                m_ptr[o]   = 0;
            end
            m_err = 0;
        end else begin
            logic [4:0]      g;
            logic [4:0][4:0] s;
            model_eval(g, s);
            for (int o = 0; o < 5; o++) begin
                for (int w = 0; w < 5; w++) begin
                    if (s[o][w]) begin
                        if (rtail[w]) begin
                            m_lock[o] = 0;
                            m_ptr[o]  = (w + 1) % 5;
                        end else begin
                            m_lock[o]  = 1;
                            m_owner[o] = w;
                        end
                    end
                end
            end
            for (int i = 0; i < 5; i++)
                if (rv[i] && $countones(dst[i]) != 1) m_err = 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [4:0]      eg;
            logic [4:0][4:0] es;
            logic [4:0]      eb;
            model_eval(eg, es);
            eb = '0;
            for (int o = 0; o < 5; o++) if (rst && m_lock[o]) eb[o] = 1'b1;
            chk("grant", grant, eg);
            for (int o = 0; o < 5; o++) chk($sformatf("sel%0d", o), sel[o], es[o]);
            chk("busy", busy, eb);
            chk("err_dest", 5'(err_dest), 5'(m_err));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [4:0] rr_exp [4];
        rr_exp = '{5'b00001, 5'b00010, 5'b10000, 5'b00001};

        rst   = 1'b1;
        rv    = '0;
        rtail = '0;
        rdy   = '1;
        for (int i = 0; i < 5; i++) dst[i] = '0;
        #1 rst = 1'b0;
        chk_en = 1;

        // Reset held with every input requesting output 0
        rv    = 5'b11111;
        rtail = 5'b11111;
        for (int i = 0; i < 5; i++) dst[i] = 5'b00001;
        tick();
        tick();
        #2;
        chk("rst_grant", grant, 5'b00000);
        chk("rst_sel0", sel[0], 5'b00000);
        chk("rst_busy", busy, 5'b00000);
        chk("rst_err", 5'(err_dest), 5'd0);
        tick();
        rst = 1'b1;
        #2;
        chk("rel_grant", grant, 5'b00001);
        chk("rel_sel0", sel[0], 5'b00001);
        tick();
        rv = '0;

        // Single-flit packet, input 2 to output 3
        dst[2] = 5'b01000;
        rv     = 5'b00100;
        rtail  = 5'b00100;
        #2;
        chk("single_sel3", sel[3], 5'b00100);
        chk("single_grant", grant, 5'b00100);
        tick();
        rv = '0;
        #2;
        chk("single_busy", busy, 5'b00000);
        chk("single_ptr3_model", 5'(m_ptr[3]), 5'd3);
        tick();

        // Round-robin among inputs 0, 1, 4 on output 1
        dst[0] = 5'b00010;
        dst[1] = 5'b00010;
        dst[4] = 5'b00010;
        rv     = 5'b10011;
        rtail  = 5'b11111;
        for (int c = 0; c < 4; c++) begin
            #2;
            chk($sformatf("rr_grant%0d", c), grant, rr_exp[c]);
            tick();
        end
        rv = '0;

        // Wormhole on output 2: head, body, bubble, tail, then contender
        dst[1] = 5'b00100;
        dst[3] = 5'b00100;
        rtail  = 5'b00000;
        rv     = 5'b00010;
        #2;
        chk("wh_head_sel2", sel[2], 5'b00010);
        chk("wh_head_grant", grant, 5'b00010);
        tick();
        rv = 5'b01010;
        #2;
        chk("wh_body_sel2", sel[2], 5'b00010);
        chk("wh_body_busy2", 5'(busy[2]), 5'd1);
        tick();
        rv = 5'b01000;
        #2;
        chk("wh_bubble_sel2", sel[2], 5'b00000);
        chk("wh_bubble_grant", grant, 5'b00000);
        tick();
        rv    = 5'b01010;
        rtail = 5'b00010;
        #2;
        chk("wh_tail_grant", grant, 5'b00010);
        tick();
        rv    = 5'b01000;
        rtail = 5'b00000;
        #2;
        chk("wh_next_sel2", sel[2], 5'b01000);
        chk("wh_next_grant", grant, 5'b01000);
        tick();
        rv = '0;

        // Backpressure on output 4
        dst[0] = 5'b10000;
        rv     = 5'b00001;
        rdy    = 5'b01111;
        for (int c = 0; c < 3; c++) begin
            #2;
            chk("bp_grant", grant, 5'b00000);
            chk("bp_sel4", sel[4], 5'b00000);
            chk("bp_busy4", 5'(busy[4]), 5'd0);
            tick();
        end
        rdy = 5'b11111;
        #2;
        chk("bp_ready_grant", grant, 5'b00001);
        chk("bp_ready_sel4", sel[4], 5'b00001);
        tick();
        rv = '0;
        #2;
        chk("bp_locked_busy", busy, 5'b10100);
        tick();

        // Bad destination, then reset while locked
        dst[3] = 5'b00110;
        rv     = 5'b01000;
        #2;
        chk("bad_grant", grant, 5'b00000);
        tick();
        rv = '0;
        #2;
        chk("bad_err", 5'(err_dest), 5'd1);
        tick();
        #2;
        chk("bad_err_sticky", 5'(err_dest), 5'd1);
        tick();
        rst = 1'b0;
        #2;
        chk("mid_rst_busy", busy, 5'b00000);
        chk("mid_rst_err", 5'(err_dest), 5'd0);
        tick();
        rst = 1'b1;
        #2;
        chk("post_rst_busy", busy, 5'b00000);
        chk("post_rst_err", 5'(err_dest), 5'd0);
        dst[4] = 5'b00100;
        rv     = 5'b10000;
        rtail  = 5'b10000;
        #1;
        chk("post_rst_grant", grant, 5'b10000);
        chk("post_rst_sel2", sel[2], 5'b10000);
        tick();
        rv = '0;
        tick();

        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/switch_allocator.md
# switch_allocator

Per-router switch allocator for the 5-port mesh router. It sits directly upstream of the crossbar and produces the five one-hot crossbar select vectors (`sel0`..`sel4`) plus per-input dequeue grants. It arbitrates contending input buffers per output port with round-robin priority. Each output is held for the whole packet (wormhole) from head flit to tail flit.

## Interface
Parameters:
- `NPORTS`, 5, router port count. Only 5 is supported; it matches the crossbar.
- `RR_INIT`, 0, reset value of every output's round-robin pointer (0..4).

Ports:
- `clk`  in  1  router clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-low.
- `req_valid`  in  5  bit i: input buffer i has a flit at its head.
- `req_dest0`..`req_dest4`  in  5 each  one-hot requested output port for the head flit of input i, from route computation.
- `req_tail`  in  5  bit i: the head flit of input i is a tail flit (a single-flit packet sets this on its head).
- `out_ready`  in  5  bit o: downstream of output o can accept a flit this cycle.
- `grant`  out  5  bit i: input i's flit crosses the switch this cycle; the input buffer pops on this edge.
- `sel0`..`sel4`  out  5 each  one-hot source input for output o; 5'b00000 means idle.
- `busy`  out  5  bit o: output o is locked to a packet in progress.
- `err_dest`  out  1  sticky flag: a valid request carried a non-one-hot `req_dest`.

## Operation
- State per output o: `lock_o` (valid bit plus 3-bit owner index) and `ptr_o` (3-bit, 0..4).
- Input i requests output o when `req_valid[i]` is set, `req_dest_i` is one-hot, and its set bit is o.
- An input with a non-one-hot destination (zero or multiple bits) is ignored and sets `err_dest`. `err_dest` clears only on reset.
- Each input requests at most one output, so no input-side conflict is possible and `grant` is the OR of the granted sources.
- Output o while locked to owner k:
  - If k requests o and `out_ready[o]`=1: `sel_o`=1<<k and `grant[k]`=1.
  - Otherwise `sel_o`=0. Other requesters are never granted o, even when k sits on a bubble.
- Output o while unlocked, with `out_ready[o]`=1 and at least one requester:
  - Winner = the first requester scanning ptr_o, ptr_o+1, … mod 5.
  - `sel_o`=1<<winner and `grant[winner]`=1.
- Update on every granted flit on output o:
  - Flit is a head and not a tail: set lock_o, owner=winner.
  - Flit is a tail: clear lock_o and set ptr_o=(owner or winner)+1 mod 5. Wrap 4→0.
  - Body flit: no state change.
- `out_ready[o]`=0: no grant on o. Lock and pointer are unchanged, and the arbitration result is not committed.
- `busy[o]` = lock_o valid.

## Timing
- `sel*` and `grant` are combinational from the current requests and registered state, with zero-cycle latency. The crossbar captures the selected input on the next rising edge, the same edge on which the buffer pops.
- Lock and pointer updates take effect from the cycle after the granted flit.
- A tail grant and a new head from another input on the same output in the same cycle: only the tail is granted. The new head may win the next cycle.
- Reset asserted, including mid-packet: all locks clear, all `ptr`=RR_INIT, `err_dest`=0. While `rst`=0, `grant`, `sel0`..`sel4` and `busy` are forced to 0.
- Sustained throughput: one flit per output per cycle.

## Structure
- Shared package `noc_pkg` holds:
  - `NPORTS`=5.
  - Port index constants P_LOCAL=0, P_NORTH=1, P_EAST=2, P_SOUTH=3, P_WEST=4.
  - The one-hot port vector type, and the function one-hot→index with a validity bit.
- Sub-module `rr_arbiter5` covers one output: request vector, pointer, lock/owner, ready → one-hot grant and next state. It is instantiated five times; the top does request decode, grant OR and error flagging.

## Test plan
1. Reset: hold `rst`=0 with `req_valid`=5'b11111 and all destinations valid → every `sel*`, `grant`, `busy` and `err_dest` reads 0. Release `rst` → grants appear in the same cycle.
2. Single flit: input 2, dest 5'b01000, tail=1, all ready → `sel3`=5'b00100 and `grant`=5'b00100 that cycle. Next cycle `busy[3]`=0 and ptr3=3.
3. Round-robin: inputs 0, 1 and 4 each send single-flit packets to output 1 every cycle, ptr1=0 → the winners over successive cycles are 0, 1, 4, 0.
4. Wormhole with bubble, in consecutive cycles:
   - Input 1 sends a head to output 2, and input 3 then also requests output 2.
   - Input 1 body: `sel2`=5'b00010.
   - Input 1 bubble: `sel2`=0 and `grant[3]`=0.
   - Input 1 tail: released.
   - Next cycle: input 3 is granted.
5. Backpressure: input 0 sends a head to output 4 with `out_ready[4]`=0 for 3 cycles → no grant, `sel4`=0, `busy[4]`=0. Ready rises → granted and locked.
6. Bad destination and reset mid-packet:
   - Input 3 with dest 5'b00110 → no grant and `err_dest`=1, which stays set.
   - Assert `rst` while output 2 is locked → lock cleared and `err_dest`=0 after release.
